// File: rtl/pico_host_pkg.sv
//------------------------------------------------------------------------------
// Module   : pico_host_pkg
// Purpose  : Shared types and constants for the picoMips host driver:
//            driver FSM state encoding, SW bus bit positions and a small
//            helper used to size the shared phase counter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package pico_host_pkg;

  typedef enum logic [2:0] {
    PROC_RST = 3'd0,
    IDLE     = 3'd1,
    PRESENT  = 3'd2,
    RELEASE  = 3'd3,
    SETTLE   = 3'd4,
    OUTPUT   = 3'd5
  } state_t;

  // Bit positions on the 10-bit switch bus
  localparam int SW_DATA_MSB = 7;
  localparam int SW_HS       = 8;
  localparam int SW_NRST     = 9;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pico_host_driver_phase_timer.sv
//------------------------------------------------------------------------------
// Module   : phase_timer
// Purpose  : Loadable down-counter that times one FSM phase. Loading N makes
//            Done assert on the Nth cycle after the load edge; the count then
//            parks at zero instead of wrapping.
// Ports    : Clock     - system clock, rising edge
//            Reset     - synchronous, active-high; clears the count
//            Load      - load LoadValue on this edge (overrides counting)
//            LoadValue - phase length in cycles
//            Done      - high while the count equals 1 (last cycle of phase)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module phase_timer #(
  parameter int WIDTH = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadValue,
  output logic             Done
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_count <= '0;
    end else if (Load) begin
      r_count <= LoadValue;
    end else if (r_count != '0) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign Done = (r_count == WIDTH'(1));

endmodule

`default_nettype wire

// File: rtl/pico_host_driver.sv
//------------------------------------------------------------------------------
// Module   : pico_host_driver
// Purpose  : Operator-side driver for the picoMips switch/LED interface.
//            Operand bytes from a valid/ready stream are presented on
//            SW[7:0] with a SW[8] high/low handshake; after the last operand
//            and a settle time the LED value is captured and returned on an
//            output valid/ready stream. SW[9] is the processor nReset.
// Ports    : Clock, Reset       - clock and synchronous active-high reset
//            InValid/InReady    - operand stream handshake, InData operand
//            SW[9:0]            - [7:0] data, [8] handshake, [9] nReset
//            LED[7:0]           - processor accumulator (signed)
//            OutValid/OutReady  - result stream handshake, OutData result
//            Busy               - low only in IDLE
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pico_host_driver
  import pico_host_pkg::*;
#(
  parameter int RESET_CYCLES  = 4,
  parameter int HOLD_CYCLES   = 16,
  parameter int OPERANDS      = 2,
  parameter int SETTLE_CYCLES = 64
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       InValid,
  output logic       InReady,
  input  logic [7:0] InData,
  output logic [9:0] SW,
  input  logic [7:0] LED,
  output logic       OutValid,
  input  logic       OutReady,
  output logic [7:0] OutData,
  output logic       Busy
);

  localparam int TW = $clog2(max3(RESET_CYCLES, HOLD_CYCLES, SETTLE_CYCLES) + 1);
  localparam int CW = $clog2(OPERANDS + 1);

  state_t          r_state;
  state_t          w_state_next;
  logic            r_armed;
  logic [9:0]      r_sw;
  logic [9:0]      w_sw_next;
  logic [CW-1:0]   r_op_cnt;
  logic [CW-1:0]   w_cnt_next;
  logic [CW-1:0]   w_cnt_inc;
  logic            r_out_valid;
  logic            w_out_valid_next;
  logic [7:0]      r_out_data;
  logic [7:0]      w_out_data_next;
  logic            w_load;
  logic [TW-1:0]   w_load_val;
  logic            w_done;
  logic            w_rst_last;

  phase_timer #(.WIDTH(TW)) u_timer (
    .Clock     (Clock),
    .Reset     (Reset),
    .Load      (w_load),
    .LoadValue (w_load_val),
    .Done      (w_done)
  );

  // PROC_RST is entered through Reset, so there is no entry edge to load the
  // timer on. Its first cycle loads RESET_CYCLES-1 instead, and r_armed marks
  // that this has happened. A one-cycle reset phase ends immediately.
  assign w_rst_last = (RESET_CYCLES == 1) ? !r_armed : (r_armed && w_done);
  assign w_cnt_inc  = r_op_cnt + CW'(1);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= PROC_RST;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_load           = 1'b0;
    w_load_val       = '0;
    w_cnt_next       = r_op_cnt;
    w_sw_next        = r_sw;
    w_out_valid_next = r_out_valid;
    w_out_data_next  = r_out_data;
    case (r_state)
      PROC_RST: begin
        if (w_rst_last) begin
          w_sw_next[SW_NRST] = 1'b1;
          w_state_next       = IDLE;
        end else if (!r_armed) begin
          w_load     = 1'b1;
          w_load_val = TW'(RESET_CYCLES - 1);
        end
      end
      IDLE: begin
        if (InValid) begin
          w_sw_next[SW_DATA_MSB:0] = InData;
          w_sw_next[SW_HS]         = 1'b1;
          w_load                   = 1'b1;
          w_load_val               = TW'(HOLD_CYCLES);
          w_state_next             = PRESENT;
        end
      end
      PRESENT: begin
        if (w_done) begin
          w_sw_next[SW_HS] = 1'b0;
          w_load           = 1'b1;
          w_load_val       = TW'(HOLD_CYCLES);
          w_state_next     = RELEASE;
        end
      end
      RELEASE: begin
        if (w_done) begin
          if (w_cnt_inc < CW'(OPERANDS)) begin
            w_cnt_next   = w_cnt_inc;
            w_state_next = IDLE;
          end else begin
            w_cnt_next   = '0;
            w_load       = 1'b1;
            w_load_val   = TW'(SETTLE_CYCLES);
            w_state_next = SETTLE;
          end
        end
      end
      SETTLE: begin
        if (w_done) begin
          w_out_data_next  = LED;
          w_out_valid_next = 1'b1;
          w_state_next     = OUTPUT;
        end
      end
      OUTPUT: begin
        if (OutReady) begin
          w_out_valid_next = 1'b0;
          w_state_next     = IDLE;
        end
      end
      default: begin
        w_state_next = PROC_RST;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_armed     <= 1'b0;
      r_sw        <= '0;
      r_op_cnt    <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_armed     <= r_armed | (r_state == PROC_RST);
      r_sw        <= w_sw_next;
      r_op_cnt    <= w_cnt_next;
      r_out_valid <= w_out_valid_next;
      r_out_data  <= w_out_data_next;
    end
  end

  assign SW       = r_sw;
  assign OutValid = r_out_valid;
  assign OutData  = r_out_data;
  assign InReady  = (r_state == IDLE);
  assign Busy     = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_pico_host_driver.sv
//------------------------------------------------------------------------------
// Module   : tb_pico_host_driver
// Purpose  : Self-checking bench for pico_host_driver with default parameters
//            (RESET_CYCLES=4, HOLD_CYCLES=16, OPERANDS=2, SETTLE_CYCLES=64).
//            Inputs change and outputs are sampled on the falling clock edge.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pico_host_driver;
  import pico_host_pkg::*;

  logic       clk = 1'b0;
  logic       Reset = 1'b1;
  logic       InValid = 1'b0;
  logic [7:0] InData = 8'h00;
  logic [7:0] LED = 8'h00;
  logic       OutReady = 1'b0;
  logic       InReady;
  logic [9:0] SW;
  logic       OutValid;
  logic [7:0] OutData;
  logic       Busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pico_host_driver dut (
    .Clock    (clk),
    .Reset    (Reset),
    .InValid  (InValid),
    .InReady  (InReady),
    .InData   (InData),
    .SW       (SW),
    .LED      (LED),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .OutData  (OutData),
    .Busy     (Busy)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] led_early;
    logic [7:0] led_final;
    int         bp;
    logic [7:0] exp;
  } vec_t;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One operand: accept from IDLE, then measure the SW[8] high and low phases.
  task automatic do_operand(input logic [7:0] d, input logic [7:0] le, input bit last);
    int hi;
    int lo;
    hi = 0;
    lo = 0;
    check("op_idle_ready", 32'(InReady), 32'd1);
    InValid = 1'b1;
    InData  = d;
    step();
    InData = 8'hAA;  // must be ignored while busy
    for (int i = 0; i < 16; i++) begin
      if (SW[SW_HS] && SW[7:0] == d && !InReady && Busy) hi++;
      LED = i[0] ? le : ~le;
      step();
    end
    check("hs_high_cycles", 32'(hi), 32'd16);
    InValid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (!SW[SW_HS] && SW[7:0] == d && SW[SW_NRST] && !InReady) lo++;
      LED = i[0] ? ~le : le;
      step();
    end
    check("hs_low_cycles", 32'(lo), 32'd16);
    check("after_op_ready", 32'(InReady), last ? 32'd0 : 32'd1);
  endtask

  task automatic run_txn(input vec_t v);
    int n;
    int cnt;
    OutReady = (v.bp == 0);
    do_operand(v.a, v.led_early, 1'b0);
    do_operand(v.b, v.led_early, 1'b1);
    n = 0;
    while (!OutValid && n < 200) begin
      LED = (n == 63) ? v.led_final : v.led_early;
      step();
      n++;
    end
    check("settle_cycles", 32'(n), 32'd64);
    LED = 8'h55;
    check("out_valid", 32'(OutValid), 32'd1);
    check("out_data", 32'(OutData), 32'(v.exp));
    if (v.bp > 0) begin
      cnt = 0;
      InValid = 1'b1;
      InData  = 8'hCC;
      for (int j = 0; j < v.bp; j++) begin
        if (OutValid && OutData == v.exp && !InReady) cnt++;
        step();
      end
      check("backpressure_hold", 32'(cnt), 32'(v.bp));
      InValid  = 1'b0;
      OutReady = 1'b1;
    end
    step();
    check("out_valid_drop", 32'(OutValid), 32'd0);
    check("back_to_idle", 32'(InReady), 32'd1);
    check("sw_data_kept", 32'(SW[7:0]), 32'(v.b));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[3];
    int   zeros;
    int   ov_bad;
    logic ir3;
    int   n;
    logic [7:0] ops[4];
    int   idx, cyc, results, ov_cycles, bad_data, n_seen, run, n_runs, bad_runs;
    logic prev_hs;
    logic acc;
    logic [7:0] seen[8];

    vecs[0] = '{8'h05, 8'hFD, 8'h02, 8'h02, 20, 8'h02};
    vecs[1] = '{8'h10, 8'h20, 8'h11, 8'h7F, 0,  8'h7F};
    vecs[2] = '{8'h80, 8'h7F, 8'h00, 8'h80, 3,  8'h80};

    // Reset held for three edges, then released
    repeat (3) step();
    check("rst_sw", 32'(SW), 32'h000);
    check("rst_in_ready", 32'(InReady), 32'd0);
    check("rst_out_valid", 32'(OutValid), 32'd0);
    check("rst_out_data", 32'(OutData), 32'd0);
    check("rst_busy", 32'(Busy), 32'd1);
    Reset  = 1'b0;
    zeros  = 0;
    ov_bad = 0;
    ir3    = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k <= 3 && !SW[SW_NRST]) zeros++;
      if (k == 3) ir3 = InReady;
      if (OutValid) ov_bad++;
    end
    check("nrst_low_cycles", 32'(zeros), 32'd3);
    check("nrst_high", 32'(SW[SW_NRST]), 32'd1);
    check("ready_before_nrst", 32'(ir3), 32'd0);
    check("ready_with_nrst", 32'(InReady), 32'd1);
    check("busy_idle", 32'(Busy), 32'd0);
    check("ov_during_rst", 32'(ov_bad), 32'd0);

    for (int i = 0; i < 3; i++) run_txn(vecs[i]);

    // Reset in the RELEASE phase of the second operand
    OutReady = 1'b1;
    do_operand(8'h21, 8'h00, 1'b0);
    InValid = 1'b1;
    InData  = 8'h42;
    step();
    InValid = 1'b0;
    repeat (21) step();
    check("mid_hs_low", 32'(SW[SW_HS]), 32'd0);
    Reset = 1'b1;
    step();
    check("mid_rst_sw", 32'(SW), 32'h000);
    check("mid_rst_ready", 32'(InReady), 32'd0);
    check("mid_rst_busy", 32'(Busy), 32'd1);
    check("mid_rst_out_data", 32'(OutData), 32'd0);
    step();
    Reset = 1'b0;
    n = 0;
    while (!InReady && n < 20) begin
      step();
      n++;
    end
    check("restart_cycles", 32'(n), 32'd4);
    run_txn('{8'h33, 8'h44, 8'h11, 8'h5A, 0, 8'h5A});
    ov_bad = 0;
    for (int i = 0; i < 150; i++) begin
      if (OutValid) ov_bad++;
      step();
    end
    check("single_result", 32'(ov_bad), 32'd0);

    // Back-to-back with InValid held high and OutReady tied high
    ops[0] = 8'h01; ops[1] = 8'h02; ops[2] = 8'h03; ops[3] = 8'h04;
    LED = 8'h33;
    OutReady = 1'b1;
    InValid  = 1'b1;
    InData   = ops[0];
    idx = 0; cyc = 0; results = 0; ov_cycles = 0; bad_data = 0;
    n_seen = 0; run = 0; n_runs = 0; bad_runs = 0;
    prev_hs = 1'b0;
    while (cyc < 600) begin
      if (SW[SW_HS] && !prev_hs && n_seen < 8) begin
        seen[n_seen] = SW[7:0];
        n_seen++;
      end
      if (SW[SW_HS]) run++;
      if (!SW[SW_HS] && prev_hs) begin
        n_runs++;
        if (run != 16) bad_runs++;
        run = 0;
      end
      prev_hs = SW[SW_HS];
      if (OutValid) begin
        results++;
        ov_cycles++;
        if (OutData != 8'h33) bad_data++;
      end
      if (results == 2 && !OutValid) break;
      acc = InReady && InValid;
      step();
      cyc++;
      if (acc) begin
        idx++;
        if (idx < 4) InData = ops[idx];
        else InValid = 1'b0;
      end
    end
    check("stream_operands", 32'(n_seen), 32'd4);
    for (int i = 0; i < 4; i++) check("stream_order", 32'(seen[i]), 32'(ops[i]));
    check("stream_hs_runs", 32'(n_runs), 32'd4);
    check("stream_hs_len", 32'(bad_runs), 32'd0);
    check("stream_results", 32'(ov_cycles), 32'd2);
    check("stream_data", 32'(bad_data), 32'd0);
    check("stream_cycles", 32'(cyc), 32'd262);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
